ipv4_tx_ctrl: RTL

IPV4_TX_CTRL -- requirements
Module: ipv4_tx_ctrl

---
 rtl/ipv4_tx_ctrl.sv | 132 +++++++++++++
 1 files changed

// File: rtl/ipv4_tx_ctrl.sv
// IPv4 transmit sequencer: emits a 20-byte header from head_i, then the payload stream, framed by the latched length.
// Optional length cross-check of pl_last_i against the latched length: define IPV4_TX_LEN_CHECK_EN.
module ipv4_tx_ctrl #(
   parameter int DATA_W = 16,
   parameter int LEN_W  = 16,
   parameter int HEAD_N = 20,
   parameter int HEAD_W = HEAD_N * 8
) (
   input  logic              clk,
   input  logic              nreset,
   input  logic              start_i,
   input  logic [LEN_W-1:0]  len_i,
   output logic              busy_o,
   output logic [LEN_W-1:0]  head_len_o,
   input  logic [HEAD_W-1:0] head_i,
   input  logic              pl_valid_i,
   input  logic [DATA_W-1:0] pl_data_i,
   input  logic              pl_last_i,
   output logic              pl_ready_o,
   output logic              tx_valid_o,
   output logic [DATA_W-1:0] tx_data_o,
   output logic [1:0]        tx_keep_o,
   output logic              tx_last_o,
   input  logic              tx_ready_i,
   output logic              err_o
);

   localparam int unsigned HEAD_WORDS = HEAD_N / 2;
   localparam int unsigned CNT_W      = $clog2(HEAD_WORDS);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] HEAD = 2'd1;
   localparam logic [1:0] DATA = 2'd2;

   logic [1:0]        state;
   logic [LEN_W-1:0]  head_len;
   logic [LEN_W-1:0]  remaining;
   logic [CNT_W-1:0]  word_cnt;
   logic [DATA_W-1:0] head_words [HEAD_WORDS];
   logic              last_head;
   logic              hs;
   logic [LEN_W-1:0]  step;

   always_comb begin
      for (int unsigned i = 0; i < HEAD_WORDS; i++) begin
         head_words[i] = head_i[i*DATA_W +: DATA_W];
      end
   end

   assign last_head  = (word_cnt == CNT_W'(HEAD_WORDS - 1));
   assign hs         = tx_valid_o & tx_ready_i;
   assign step       = (remaining >= LEN_W'(2)) ? LEN_W'(2) : remaining;
   assign busy_o     = (state != IDLE);
   assign head_len_o = head_len;

   always_comb begin
      tx_valid_o = 1'b0;
      tx_data_o  = '0;
      tx_keep_o  = 2'b00;
      tx_last_o  = 1'b0;
      pl_ready_o = 1'b0;
      case (state)
         HEAD: begin
            tx_valid_o = 1'b1;
            tx_data_o  = head_words[word_cnt];
            tx_keep_o  = 2'b11;
            tx_last_o  = last_head && (head_len == '0);
         end
         DATA: begin
            tx_valid_o = pl_valid_i;
            tx_data_o  = pl_data_i;
            tx_keep_o  = (remaining == LEN_W'(1)) ? 2'b01 : 2'b11;
            tx_last_o  = (remaining <= LEN_W'(2));
            pl_ready_o = tx_ready_i;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         state     <= IDLE;
         head_len  <= '0;
         remaining <= '0;
         word_cnt  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start_i) begin
                  head_len  <= len_i;
                  remaining <= len_i;
                  word_cnt  <= '0;
                  state     <= HEAD;
               end
            end
            HEAD: begin
               if (hs) begin
                  if (last_head) begin
                     word_cnt <= '0;
                     state    <= (head_len == '0) ? IDLE : DATA;
                  end else begin
                     word_cnt <= word_cnt + 1'b1;
                  end
               end
            end
            DATA: begin
               if (hs) begin
                  remaining <= remaining - step;
                  if (tx_last_o) state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef IPV4_TX_LEN_CHECK_EN
   logic err;

   // Sequencing ignores pl_last_i; a disagreement only raises a pulse.
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) err <= 1'b0;
      else         err <= (state == DATA) && hs && (pl_last_i != tx_last_o);
   end
   assign err_o = err;
`else
   logic unused_pl_last;
   assign unused_pl_last = pl_last_i;
   assign err_o          = 1'b0;
`endif

endmodule
